wb_checkpoint_monitor: RTL and testbench

Self-checking simulation/debug monitor that sits beside the Riscv151 core and snoops the register-file writeback port.
- Keeps a shadow copy of the architectural registers.
- When the test program writes a checkpoint number to the flag register, it stalls the core and checks that checkpoint's expected (register, value) entries against the shadow file, one entry per cycle.
- Generalises a fixed flag-register test sequence into a parametrised, table-driven checker with timeout and ordered-checkpoint detection.

---
 rtl/wb_checkpoint_monitor.sv | 240 ++++++++++++++++++++++++
 tb/tb_wb_checkpoint_monitor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_checkpoint_monitor.sv
// wb_checkpoint_monitor
//   Debug monitor beside the Riscv151 core. Snoops the register-file writeback
//   port into a shadow register file. A test program signals checkpoint N by
//   writing N to register FLAG_REG; the monitor then stalls the core and checks
//   every preloaded (ckpt, reg, value) entry for N against the shadow file, one
//   entry per cycle. The table must be loaded in non-decreasing checkpoint order.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   wb_en/addr/data   regfile writeback snoop
//   tbl_wr_en/ckpt/reg/value  table append (LOAD only)
//   start             LOAD -> RUN
//   stall             high in CHECK; core must freeze
//   done, pass        sticky terminal status
//   fail_code/ckpt/reg/got/exp  failure details, stable once done
//   checks_passed     saturating count of matched entries
module wb_checkpoint_monitor #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned CKPT_W   = 8,
    parameter int unsigned FLAG_REG = 20,
    parameter int unsigned TIMEOUT  = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              tbl_wr_en,
    input  logic [CKPT_W-1:0] tbl_ckpt,
    input  logic [4:0]        tbl_reg,
    input  logic [XLEN-1:0]   tbl_value,
    input  logic              start,
    output logic              stall,
    output logic              done,
    output logic              pass,
    output logic [2:0]        fail_code,
    output logic [CKPT_W-1:0] fail_ckpt,
    output logic [4:0]        fail_reg,
    output logic [XLEN-1:0]   fail_got,
    output logic [XLEN-1:0]   fail_exp,
    output logic [15:0]       checks_passed
);
    localparam int unsigned IdxW   = $clog2(DEPTH);
    localparam int unsigned PtrW   = IdxW + 1;
    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

    localparam logic [4:0]        FlagIdx   = 5'(FLAG_REG);
    localparam logic [PtrW-1:0]   Full      = PtrW'(DEPTH);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

    localparam logic [2:0] FcMismatch = 3'd1;
    localparam logic [2:0] FcMissed   = 3'd2;
    localparam logic [2:0] FcTimeout  = 3'd3;
    localparam logic [2:0] FcOverflow = 3'd4;
    localparam logic [2:0] FcOrder    = 3'd5;
    localparam logic [2:0] FcStall    = 3'd6;

    typedef enum logic [2:0] {StLoad, StRun, StCheck, StPass, StFail} state_e;
    state_e state_q, state_d;

    logic [CKPT_W-1:0] mem_ckpt  [DEPTH];
    logic [4:0]        mem_reg   [DEPTH];
    logic [XLEN-1:0]   mem_value [DEPTH];
    logic [XLEN-1:0]   shadow_q  [32];

    logic [PtrW-1:0]   cnt_q, rd_ptr_q;
    logic [TimerW-1:0] timer_q;
    logic              ovf_q, ord_q;
    logic [CKPT_W-1:0] prev_ckpt_q, n_q;
    logic [15:0]       checks_q;
    logic [2:0]        fail_code_q;
    logic [CKPT_W-1:0] fail_ckpt_q;
    logic [4:0]        fail_reg_q;
    logic [XLEN-1:0]   fail_got_q, fail_exp_q;

    logic              fail_load;
    logic [2:0]        fail_code_d;
    logic [4:0]        fail_reg_d;
    logic [XLEN-1:0]   fail_got_d, fail_exp_d;

    logic [IdxW-1:0]   rd_idx;
    logic [CKPT_W-1:0] e_ckpt;
    logic [4:0]        e_reg;
    logic [XLEN-1:0]   e_value, e_got;
    logic              flag_hit, entry_left, do_match, shadow_we, tbl_we;

    assign rd_idx     = rd_ptr_q[IdxW-1:0];
    assign e_ckpt     = mem_ckpt[rd_idx];
    assign e_reg      = mem_reg[rd_idx];
    assign e_value    = mem_value[rd_idx];
    // shadow_q[0] is never written, so x0 always reads 0
    assign e_got      = shadow_q[e_reg];
    assign flag_hit   = wb_en && (wb_addr == FlagIdx);
    assign entry_left = (rd_ptr_q != cnt_q);
    assign do_match   = (state_q == StCheck) && !wb_en && entry_left &&
                        (e_ckpt == n_q) && (e_got == e_value);
    // CHECK writes are a stall violation and are dropped
    assign shadow_we  = wb_en && (wb_addr != 5'd0) && (state_q != StCheck);
    assign tbl_we     = (state_q == StLoad) && tbl_wr_en && (cnt_q != Full);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StLoad;
        else     state_q <= state_d;
    end

    // Next-state and failure capture
    always_comb begin
        state_d     = state_q;
        fail_load   = 1'b0;
        fail_code_d = 3'd0;
        fail_reg_d  = '0;
        fail_got_d  = '0;
        fail_exp_d  = '0;
        unique case (state_q)
            StLoad: begin
                if (start) begin
                    if (ovf_q) begin
                        state_d = StFail; fail_load = 1'b1; fail_code_d = FcOverflow;
                    end else if (ord_q) begin
                        state_d = StFail; fail_load = 1'b1; fail_code_d = FcOrder;
                    end else if (cnt_q == '0) begin
                        state_d = StPass;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (flag_hit) begin
                    state_d = StCheck;
                end else if (timer_q == TimerLast) begin
                    state_d = StFail; fail_load = 1'b1; fail_code_d = FcTimeout;
                end
            end
            StCheck: begin
                if (wb_en) begin
                    state_d = StFail; fail_load = 1'b1; fail_code_d = FcStall;
                end else if (!entry_left) begin
                    // Final entry was matched last cycle: whole table verified
                    state_d = StPass;
                end else if (e_ckpt < n_q) begin
                    state_d = StFail; fail_load = 1'b1; fail_code_d = FcMissed;
                end else if (e_ckpt == n_q) begin
                    if (e_got != e_value) begin
                        state_d     = StFail;
                        fail_load   = 1'b1;
                        fail_code_d = FcMismatch;
                        fail_reg_d  = e_reg;
                        fail_got_d  = e_got;
                        fail_exp_d  = e_value;
                    end
                end else begin
                    state_d = StRun;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        stall = (state_q == StCheck);
        done  = (state_q == StPass) || (state_q == StFail);
        pass  = (state_q == StPass);
    end

    assign fail_code     = fail_code_q;
    assign fail_ckpt     = fail_ckpt_q;
    assign fail_reg      = fail_reg_q;
    assign fail_got      = fail_got_q;
    assign fail_exp      = fail_exp_q;
    assign checks_passed = checks_q;

    // Expectation table storage (no reset; validity tracked by cnt_q)
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            mem_ckpt[cnt_q[IdxW-1:0]]  <= tbl_ckpt;
            mem_reg[cnt_q[IdxW-1:0]]   <= tbl_reg;
            mem_value[cnt_q[IdxW-1:0]] <= tbl_value;
        end
    end

    // Datapath state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            timer_q     <= '0;
            ovf_q       <= 1'b0;
            ord_q       <= 1'b0;
            prev_ckpt_q <= '0;
            n_q         <= '0;
            checks_q    <= '0;
            fail_code_q <= '0;
            fail_ckpt_q <= '0;
            fail_reg_q  <= '0;
            fail_got_q  <= '0;
            fail_exp_q  <= '0;
        end else begin
            if (shadow_we) shadow_q[wb_addr] <= wb_data;

            if (state_q == StLoad && tbl_wr_en) begin
                if (cnt_q == Full) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q       <= cnt_q + 1'b1;
                    prev_ckpt_q <= tbl_ckpt;
                end
                if (cnt_q != '0 && tbl_ckpt < prev_ckpt_q) ord_q <= 1'b1;
            end

            if (state_q == StLoad) begin
                timer_q <= '0;
            end else if (state_q == StRun) begin
                if (flag_hit) begin
                    timer_q <= '0;
                    n_q     <= wb_data[CKPT_W-1:0];
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end

            if (do_match) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                if (checks_q != 16'hFFFF) checks_q <= checks_q + 16'd1;
            end

            if (fail_load) begin
                fail_code_q <= fail_code_d;
                fail_ckpt_q <= n_q;
                fail_reg_q  <= fail_reg_d;
                fail_got_q  <= fail_got_d;
                fail_exp_q  <= fail_exp_d;
            end
        end
    end
endmodule

// File: tb/tb_wb_checkpoint_monitor.sv
// Self-checking bench for wb_checkpoint_monitor (DEPTH=4, TIMEOUT=50).
module tb_wb_checkpoint_monitor;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned CKPT_W  = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 50;
    localparam int unsigned NVEC    = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              tbl_wr_en;
    logic [CKPT_W-1:0] tbl_ckpt;
    logic [4:0]        tbl_reg;
    logic [XLEN-1:0]   tbl_value;
    logic              start;
    logic              stall, done, pass;
    logic [2:0]        fail_code;
    logic [CKPT_W-1:0] fail_ckpt;
    logic [4:0]        fail_reg;
    logic [XLEN-1:0]   fail_got, fail_exp;
    logic [15:0]       checks_passed;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        stall;
        logic        done;
        logic        pass;
        logic [2:0]  code;
        logic [15:0] cp;
    } vec_t;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    wb_checkpoint_monitor #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .CKPT_W  (CKPT_W),
        .FLAG_REG(20),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_ckpt     (tbl_ckpt),
        .tbl_reg      (tbl_reg),
        .tbl_value    (tbl_value),
        .start        (start),
        .stall        (stall),
        .done         (done),
        .pass         (pass),
        .fail_code    (fail_code),
        .fail_ckpt    (fail_ckpt),
        .fail_reg     (fail_reg),
        .fail_got     (fail_got),
        .fail_exp     (fail_exp),
        .checks_passed(checks_passed)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; wb_en = 1'b0; tbl_wr_en = 1'b0; start = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [7:0] c, input logic [4:0] r, input logic [31:0] v);
        tbl_wr_en = 1'b1; tbl_ckpt = c; tbl_reg = r; tbl_value = v;
        tick();
        tbl_wr_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_done(input string nm, input int max);
        for (int i = 0; i < max; i++) begin
            if (done) break;
            tick();
        end
        chk(nm, 32'(done), 32'd1);
    endtask

    task automatic load_s1();
        load(8'd1, 5'd11, 32'd3);
        load(8'd1, 5'd12, 32'd5);
        load(8'd2, 5'd11, 32'd7);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < NVEC; i++) begin
            wb_en = vecs[i].en; wb_addr = vecs[i].addr; wb_data = vecs[i].data;
            tick();
            wb_en = 1'b0;
            chk($sformatf("%s_r%0d_stall", tag, i), 32'(stall), 32'(vecs[i].stall));
            chk($sformatf("%s_r%0d_done", tag, i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("%s_r%0d_pass", tag, i), 32'(pass), 32'(vecs[i].pass));
            chk($sformatf("%s_r%0d_code", tag, i), 32'(fail_code), 32'(vecs[i].code));
            chk($sformatf("%s_r%0d_cp", tag, i), 32'(checks_passed), 32'(vecs[i].cp));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Scenario 1 timeline: stall for 3 cycles at ckpt 1, 2 cycles at ckpt 2, then PASS.
        //             en    addr   data    stall done  pass  code  cp
        vecs[0]  = '{1'b1, 5'd11, 32'd3, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[1]  = '{1'b1, 5'd12, 32'd5, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[2]  = '{1'b1, 5'd20, 32'd1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0};
        vecs[3]  = '{1'b0, 5'd0,  32'd0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd1};
        vecs[4]  = '{1'b0, 5'd0,  32'd0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd2};
        vecs[5]  = '{1'b0, 5'd0,  32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd2};
        vecs[6]  = '{1'b1, 5'd11, 32'd7, 1'b0, 1'b0, 1'b0, 3'd0, 16'd2};
        vecs[7]  = '{1'b1, 5'd20, 32'd2, 1'b1, 1'b0, 1'b0, 3'd0, 16'd2};
        vecs[8]  = '{1'b0, 5'd0,  32'd0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd3};
        vecs[9]  = '{1'b0, 5'd0,  32'd0, 1'b0, 1'b1, 1'b1, 3'd0, 16'd3};
        vecs[10] = '{1'b1, 5'd20, 32'd1, 1'b0, 1'b1, 1'b1, 3'd0, 16'd3};

        rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0; start = 1'b0;
        tbl_wr_en = 1'b0; tbl_ckpt = '0; tbl_reg = '0; tbl_value = '0;

        // Reset state
        do_reset();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_code", 32'(fail_code), 32'd0);
        chk("rst_cp", 32'(checks_passed), 32'd0);
        chk("rst_got", fail_got, 32'd0);

        // 1: full pass
        load_s1();
        do_start();
        run_table("s1");

        // 2: mismatch on x12
        do_reset();
        load_s1();
        do_start();
        wb(5'd11, 32'd3); wb(5'd12, 32'd6); wb(5'd20, 32'd1);
        wait_done("s2_done", 10);
        chk("s2_code", 32'(fail_code), 32'd1);
        chk("s2_ckpt", 32'(fail_ckpt), 32'd1);
        chk("s2_reg", 32'(fail_reg), 32'd12);
        chk("s2_got", fail_got, 32'd6);
        chk("s2_exp", fail_exp, 32'd5);
        chk("s2_pass", 32'(pass), 32'd0);
        chk("s2_cp", 32'(checks_passed), 32'd1);
        chk("s2_stall", 32'(stall), 32'd0);

        // 3: checkpoint 1 skipped
        do_reset();
        load_s1();
        do_start();
        wb(5'd20, 32'd2);
        wait_done("s3_done", 10);
        chk("s3_code", 32'(fail_code), 32'd2);
        chk("s3_ckpt", 32'(fail_ckpt), 32'd2);

        // 4a: timeout on exactly the 50th RUN cycle
        do_reset();
        load(8'd5, 5'd1, 32'd0);
        do_start();
        idle(49);
        chk("s4_before_to", 32'(done), 32'd0);
        tick();
        chk("s4_at_to", 32'(done), 32'd1);
        chk("s4_code", 32'(fail_code), 32'd3);
        chk("s4_ckpt", 32'(fail_ckpt), 32'd0);

        // 4b: flag writes every 40 cycles keep the timer alive
        do_reset();
        load(8'd5, 5'd1, 32'd0);
        do_start();
        for (int k = 0; k < 3; k++) begin
            idle(39);
            wb(5'd20, 32'd0);
            chk($sformatf("s4b_stall%0d", k), 32'(stall), 32'd1);
            tick();
            chk($sformatf("s4b_alive%0d", k), 32'(done), 32'd0);
        end
        wb(5'd20, 32'd3);
        tick();
        idle(49);
        chk("s4c_before_to", 32'(done), 32'd0);
        tick();
        chk("s4c_code", 32'(fail_code), 32'd3);
        chk("s4c_ckpt", 32'(fail_ckpt), 32'd3);

        // 5: overflow, order error, empty table
        do_reset();
        for (int i = 0; i < 5; i++) load(8'(i + 1), 5'd1, 32'd0);
        do_start();
        chk("s5_ovf_done", 32'(done), 32'd1);
        chk("s5_ovf_code", 32'(fail_code), 32'd4);
        do_reset();
        load(8'd2, 5'd1, 32'd0);
        load(8'd1, 5'd1, 32'd0);
        do_start();
        chk("s5_ord_code", 32'(fail_code), 32'd5);
        chk("s5_ord_pass", 32'(pass), 32'd0);
        do_reset();
        do_start();
        chk("s5_empty_pass", 32'(pass), 32'd1);
        chk("s5_empty_done", 32'(done), 32'd1);

        // 6a: writeback during CHECK
        do_reset();
        load_s1();
        do_start();
        wb(5'd11, 32'd3); wb(5'd12, 32'd5); wb(5'd20, 32'd1);
        chk("s6_in_check", 32'(stall), 32'd1);
        wb(5'd5, 32'd9);
        chk("s6_code", 32'(fail_code), 32'd6);
        chk("s6_ckpt", 32'(fail_ckpt), 32'd1);
        chk("s6_stall", 32'(stall), 32'd0);
        chk("s6_done", 32'(done), 32'd1);

        // 6b: reset mid-CHECK, then rerun scenario 1
        do_reset();
        load_s1();
        do_start();
        wb(5'd11, 32'd3); wb(5'd12, 32'd5); wb(5'd20, 32'd1);
        tick();
        chk("s6b_cp_mid", 32'(checks_passed), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6b_stall", 32'(stall), 32'd0);
        chk("s6b_done", 32'(done), 32'd0);
        chk("s6b_cp", 32'(checks_passed), 32'd0);
        load_s1();
        do_start();
        run_table("s6r");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
